// File: rtl/pll_ctrl_pkg.sv
// Shared types and widths for the PLL reset sequencer.
package pll_ctrl_pkg;

  // Sequencer states; the encoding is visible on o_state.
  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_ctrl_state_t;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // Largest of three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the PLL lock flag into the reference clock domain.
module pll_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Two-stage capture; both stages clear to "not locked" so a reset never shows a stale lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, debounces it, then
// releases the system reset. Retries on lock timeout, gives up after MAX_RETRY
// failures, and restarts on lock loss or on a relock request.
// Optional build macro PLLCTRL_LOSS_CNT_EN adds the o_loss_cnt lock-loss counter.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic               i_clk,
  input  logic               i_nrst,
  input  logic               i_pll_locked,
  input  logic               i_relock,
  output logic               o_pll_rst,
  output logic               o_sys_nrst,
  output logic [2:0]         o_state,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic               o_fail
`ifdef PLLCTRL_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  o_loss_cnt
`endif
);

  // One counter serves all timed phases, so it is sized for the longest one.
  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  pll_ctrl_state_t    state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [RETRY_W-1:0] retry, retry_next;
  logic               lock_s;

  pll_lock_sync u_lock_sync (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .async_in (i_pll_locked),
    .sync_out (lock_s)
  );

`ifdef PLLCTRL_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_cnt;
  logic              loss_event;

  // RUN with lock gone always leaves for RST, even when a relock arrives in the same cycle.
  assign loss_event = (state == ST_RUN) && !lock_s;
  assign o_loss_cnt = loss_cnt;
`endif

  // Next-state, counter and retry decisions; relock overrides everything.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths that skip it infer a latch.
    state_next = state;
    cnt_next   = cnt + 1'b1;
    retry_next = retry;

    case (state)
      ST_RST: begin
        if (cnt == RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_next = (retry == RETRY_LIMIT) ? retry : retry + 1'b1;
          state_next = (retry_next == RETRY_LIMIT) ? ST_FAIL : ST_RST;
        end
      end
      ST_STABLE: begin
        // A lock dropout restarts the wait without costing a retry.
        if (!lock_s)                  state_next = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_next = ST_RUN;
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!lock_s) state_next = ST_RST;
      end
      ST_FAIL: begin
        cnt_next = '0;
      end
      default: begin
        state_next = ST_RST;
      end
    endcase

    // A successful bring-up forgives earlier failed attempts.
    if (state_next == ST_RUN) retry_next = '0;

    if (i_relock) begin
      state_next = ST_RST;
      retry_next = '0;
    end

    // Each phase times itself from zero; relock restarts RST even when already there.
    if ((state_next != state) || i_relock) cnt_next = '0;
  end

  // State, counter, retry and registered outputs; outputs follow state_next so they move with the state.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state      <= ST_RST;
      cnt        <= '0;
      retry      <= '0;
      o_pll_rst  <= 1'b1;
      o_sys_nrst <= 1'b0;
      o_fail     <= 1'b0;
`ifdef PLLCTRL_LOSS_CNT_EN
      loss_cnt   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples the pre-edge values.
      state      <= state_next;
      cnt        <= cnt_next;
      retry      <= retry_next;
      o_pll_rst  <= (state_next == ST_RST) || (state_next == ST_FAIL);
      o_sys_nrst <= (state_next == ST_RUN);
      o_fail     <= (state_next == ST_FAIL);
`ifdef PLLCTRL_LOSS_CNT_EN
      if (loss_event && (loss_cnt != '1)) loss_cnt <= loss_cnt + 1'b1;
`endif
    end
  end

  assign o_state     = state;
  assign o_retry_cnt = retry;

endmodule
